coin_acceptor: RTL and testbench

Front-end for the newspaper vending controller: turns raw nickel and dime sensor levels from the coin mechanism into clean `coin` codes that meet the controller's input timing. Each code is held for exactly one clock and followed by a guaranteed idle gap. Accepted coins are queued so that a fast burst of insertions is never lost. The block sits between the coin mechanism pins and the `coin` input of the vending controller, and it listens to `newspaper` so it does not issue coins during a vend.

---
 rtl/coin_pkg.sv | 15 +
 rtl/coin_debounce.sv | 49 ++++
 rtl/coin_acceptor.sv | 184 ++++++++++++++++++
 tb/tb_coin_acceptor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared coin codes and acceptor FSM states; imported by the acceptor,
// the vending controller and the benches so everyone agrees on the encoding.
package coin_pkg;

   localparam logic [1:0] COIN_NONE = 2'd0;
   localparam logic [1:0] COIN_5    = 2'd1;
   localparam logic [1:0] COIN_10   = 2'd2;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      GAP
   } coin_acc_state_t;

endpackage

// File: rtl/coin_debounce.sv
// Two-flop synchronizer plus run-length debouncer for one raw coin sensor.
// o_accept is a one-clock pulse on the clock edge where the state flips 0->1.
module coin_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic i_sense,
   output logic o_accept
);

   localparam int RUN_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_state;
   logic [RUN_W-1:0] r_run;
   logic             w_differ;
   logic             w_flip;

   assign w_differ = (r_sync2 != r_state);
   assign w_flip   = w_differ && (r_run == RUN_LAST);

   // The accept is combinational from the flip condition so the queue push
   // lands on the same edge the debounced state changes.
   assign o_accept = w_flip && r_sync2;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_state <= 1'b0;
         r_run   <= '0;
      end else begin
         r_sync1 <= i_sense;
         r_sync2 <= r_sync1;
         if (w_flip) begin
            r_state <= r_sync2;
            r_run   <= '0;
         end else if (w_differ) begin
            r_run <= r_run + 1'b1;
         end else begin
            r_run <= '0;
         end
      end
   end

endmodule

// File: rtl/coin_acceptor.sv
// Coin front-end: debounced nickel/dime sensors, coin queue and pulse/gap FSM
// feeding the vending controller. Define COIN_ACCEPTOR_FIFO_EN for a real queue.
module coin_acceptor
   import coin_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int PULSE_CYCLES    = 1,
   parameter int GAP_CYCLES      = 2,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       nickel_sense,
   input  logic       dime_sense,
   input  logic       newspaper,
   output logic [1:0] coin,
   output logic       busy,
   output logic       dropped,
   output logic       jam
);

   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_badDepth
      $error("coin_acceptor: FIFO_DEPTH must be a power of two in 2..16");
   end
   if (PULSE_CYCLES < 1 || PULSE_CYCLES > 15 || GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_badTiming
      $error("coin_acceptor: PULSE_CYCLES and GAP_CYCLES must be in 1..15");
   end

   localparam int TMR_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_CYCLES - 1);
   localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYCLES - 1);

   logic            w_nickelAccept;
   logic            w_dimeAccept;
   logic            w_push;
   logic            w_stored;
   logic [1:0]      w_pushCode;
   logic            w_pop;
   logic            w_empty;
   logic            w_full;
   logic [1:0]      w_head;
   logic            w_canIssue;

   coin_acc_state_t r_state;
   logic [TMR_W-1:0] r_timer;
   logic [1:0]      r_coin;
   logic            r_dropped;
   logic            r_jam;

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickelDebounce (
      .clock    (clock),
      .reset    (reset),
      .i_sense  (nickel_sense),
      .o_accept (w_nickelAccept)
   );

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dimeDebounce (
      .clock    (clock),
      .reset    (reset),
      .i_sense  (dime_sense),
      .o_accept (w_dimeAccept)
   );

   // Simultaneous accepts are ambiguous, so neither coin is credited.
   assign w_push     = w_nickelAccept ^ w_dimeAccept;
   assign w_pushCode = w_nickelAccept ? COIN_5 : COIN_10;
   assign w_stored   = w_push && (!w_full || w_pop);

   assign w_canIssue = !w_empty && !newspaper;
   assign w_pop      = w_canIssue &&
                       ((r_state == IDLE) || ((r_state == GAP) && (r_timer == GAP_LAST)));

`ifdef COIN_ACCEPTOR_FIFO_EN
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [1:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_head  = r_mem[r_rptr];

   always_ff @(posedge clock) begin
      if (w_stored) begin
         r_mem[r_wptr] <= w_pushCode;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_stored) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         r_count <= r_count + CNT_W'(w_stored) - CNT_W'(w_pop);
      end
   end
`else
   logic [1:0] r_hold;
   logic       r_valid;

   assign w_empty = !r_valid;
   assign w_full  = r_valid;
   assign w_head  = r_hold;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_hold  <= COIN_NONE;
         r_valid <= 1'b0;
      end else if (w_stored) begin
         r_hold  <= w_pushCode;
         r_valid <= 1'b1;
      end else if (w_pop) begin
         r_valid <= 1'b0;
      end
   end
`endif

   // The last GAP clock pops directly into DRIVE so queued coins leave at a
   // PULSE+GAP period without an extra IDLE clock in between.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= IDLE;
         r_timer   <= '0;
         r_coin    <= COIN_NONE;
         r_dropped <= 1'b0;
         r_jam     <= 1'b0;
      end else begin
         r_dropped <= w_push && !w_stored;
         r_jam     <= w_nickelAccept && w_dimeAccept;
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_coin  <= w_head;
                  r_timer <= '0;
                  r_state <= DRIVE;
               end
            end
            DRIVE: begin
               if (r_timer == PULSE_LAST) begin
                  r_coin  <= COIN_NONE;
                  r_timer <= '0;
                  r_state <= GAP;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            GAP: begin
               if (r_timer == GAP_LAST) begin
                  r_timer <= '0;
                  if (w_pop) begin
                     r_coin  <= w_head;
                     r_state <= DRIVE;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            default: begin
               r_coin  <= COIN_NONE;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign coin    = r_coin;
   assign busy    = (r_state != IDLE) || !w_empty;
   assign dropped = r_dropped;
   assign jam     = r_jam;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: per-cycle vector table plus burst, ordering
// and reset sequences. Queue capacity follows COIN_ACCEPTOR_FIFO_EN.
module tb_coin_acceptor;
   import coin_pkg::*;

`ifdef COIN_ACCEPTOR_FIFO_EN
   localparam int CAPACITY = 4;
`else
   localparam int CAPACITY = 1;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       nickelSense;
   logic       dimeSense;
   logic       newspaper;
   logic [1:0] coin;
   logic       busy;
   logic       dropped;
   logic       jam;

   int checks      = 0;
   int failures    = 0;
   int seenCoin    = 0;
   int seenDropped = 0;
   int seenJam     = 0;
   int seenBusy    = 0;

   typedef struct {
      logic       nickel;
      logic       dime;
      logic       news;
      logic [1:0] coin;
      logic       busy;
      logic       dropped;
      logic       jam;
   } vec_t;

   vec_t vecs[$];

   always #5 clock = ~clock;

   coin_acceptor #(
      .DEBOUNCE_CYCLES (4),
      .PULSE_CYCLES    (1),
      .GAP_CYCLES      (2),
      .FIFO_DEPTH      (4)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .nickel_sense (nickelSense),
      .dime_sense   (dimeSense),
      .newspaper    (newspaper),
      .coin         (coin),
      .busy         (busy),
      .dropped      (dropped),
      .jam          (jam)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Drive inputs, advance one edge, then sample 1 time unit later.
   task automatic applyStimulus(input logic n, input logic d, input logic news);
      nickelSense = n;
      dimeSense   = d;
      newspaper   = news;
      @(posedge clock);
      #1;
      if (coin != COIN_NONE) seenCoin++;
      if (dropped) seenDropped++;
      if (jam) seenJam++;
      if (busy) seenBusy++;
   endtask

   task automatic clearSeen();
      seenCoin    = 0;
      seenDropped = 0;
      seenJam     = 0;
      seenBusy    = 0;
   endtask

   task automatic insertCoin(input logic isDime, input logic news);
      for (int i = 0; i < 6; i++) applyStimulus(!isDime, isDime, news);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, news);
   endtask

   function automatic vec_t mkVec(input logic n, input logic d, input logic news,
                                  input logic [1:0] c, input logic b,
                                  input logic dr, input logic j);
      vec_t v;
      v.nickel = n; v.dime = d; v.news = news;
      v.coin = c; v.busy = b; v.dropped = dr; v.jam = j;
      return v;
   endfunction

   initial begin
      // Nickel held 10 clocks: coin=1 six edges after the first sampled high.
      for (int i = 0; i < 18; i++)
         vecs.push_back(mkVec(i < 10, 1'b0, 1'b0, (i == 6) ? COIN_5 : COIN_NONE,
                              (i >= 5 && i <= 8), 1'b0, 1'b0));
      // Two-clock dime glitch: nothing at all.
      for (int i = 0; i < 8; i++)
         vecs.push_back(mkVec(1'b0, i < 2, 1'b0, COIN_NONE, 1'b0, 1'b0, 1'b0));
      // Both sensors together: one jam pulse, no coin, never busy.
      for (int i = 0; i < 16; i++)
         vecs.push_back(mkVec(i < 8, i < 8, 1'b0, COIN_NONE, 1'b0, 1'b0, (i == 5)));

      reset = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("reset coin", int'(coin), 0);
      checkOutput("reset busy", int'(busy), 0);
      checkOutput("reset dropped", int'(dropped), 0);
      checkOutput("reset jam", int'(jam), 0);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].nickel, vecs[i].dime, vecs[i].news);
         checkOutput($sformatf("vec%0d coin", i), int'(coin), int'(vecs[i].coin));
         checkOutput($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].busy));
         checkOutput($sformatf("vec%0d dropped", i), int'(dropped), int'(vecs[i].dropped));
         checkOutput($sformatf("vec%0d jam", i), int'(jam), int'(vecs[i].jam));
      end

      // Five dimes while the controller is vending: overflow drops the excess.
      clearSeen();
      for (int k = 0; k < 5; k++) insertCoin(1'b1, 1'b1);
      checkOutput("burst dropped count", seenDropped, 5 - CAPACITY);
      checkOutput("burst coin while stalled", seenCoin, 0);
      checkOutput("burst jam count", seenJam, 0);
      checkOutput("burst busy held", int'(busy), 1);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("drain%0d coin", i), int'(coin),
                     (i < 3 * CAPACITY && i % 3 == 0) ? int'(COIN_10) : 0);
         checkOutput($sformatf("drain%0d busy", i), int'(busy), (i < 3 * CAPACITY) ? 1 : 0);
      end

      // Nickel then dime one clock apart: 1,0,0,2,0,0 with no idle clock.
      clearSeen();
      for (int i = 0; i < 16; i++) begin
         applyStimulus(i < 8, (i >= 1 && i < 9), 1'b0);
         checkOutput($sformatf("seq%0d coin", i), int'(coin),
                     (i == 6) ? int'(COIN_5) : ((i == 9) ? int'(COIN_10) : 0));
         checkOutput($sformatf("seq%0d busy", i), int'(busy), (i >= 5 && i <= 11) ? 1 : 0);
      end
      checkOutput("seq jam count", seenJam, 0);
      checkOutput("seq dropped count", seenDropped, 0);

      // Reset while driving with coins queued discards everything.
      insertCoin(1'b0, 1'b1);
      insertCoin(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("pre-reset coin", int'(coin), int'(COIN_5));
      checkOutput("pre-reset busy", int'(busy), 1);
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("mid reset coin", int'(coin), 0);
      checkOutput("mid reset busy", int'(busy), 0);
      checkOutput("mid reset dropped", int'(dropped), 0);
      reset = 1'b0;
      clearSeen();
      for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("post reset coin count", seenCoin, 0);
      checkOutput("post reset busy count", seenBusy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
